// File: rtl/exec_alu_seq_pkg.sv
// Shared definitions for the execute unit that feeds the accumulator:
// opcodes, FSM encoding and datapath defaults.
package exec_alu_seq_pkg;

    localparam int W_DEF    = 32;
    localparam int CNTW_DEF = 6;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_PASS = 4'd10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_PASS;
    endfunction

endpackage

// File: rtl/exec_alu_seq_muldiv_iter.sv
// Shared iterative multiply/divide datapath: one shift-add or shift-subtract
// step per clock on a 2W register laid out as {high/remainder, low/quotient}.
module exec_alu_seq_muldiv_iter
    import exec_alu_seq_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic         execlk,
    input  logic         rst_n,
    input  logic         load,
    input  md_mode_e     mode_in,
    input  logic         step,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         done,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] res_hi
);

    logic [2*W-1:0]  sr_q, sr_d;
    logic [W-1:0]    opb_q, opb_d;
    md_mode_e        mode_q, mode_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [W:0]      mul_sum;
    logic [W:0]      div_trial;
    logic [W:0]      div_diff;
    logic [2*W-1:0]  sr_step;

    always_comb begin
        mul_sum   = {1'b0, sr_q[2*W-1:W]} + (sr_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        // Partial remainder shifted left by one, pulling in the next dividend bit.
        div_trial = {sr_q[2*W-1:W], sr_q[W-1]};
        div_diff  = div_trial - {1'b0, opb_q};

        if (mode_q == MD_DIV) begin
            if (div_trial >= {1'b0, opb_q}) begin
                sr_step = {div_diff[W-1:0], sr_q[W-2:0], 1'b1};
            end else begin
                sr_step = {div_trial[W-1:0], sr_q[W-2:0], 1'b0};
            end
        end else begin
            sr_step = {mul_sum, sr_q[W-1:1]};
        end

        sr_d   = sr_q;
        opb_d  = opb_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (load) begin
            sr_d   = {{W{1'b0}}, op_a};
            opb_d  = op_b;
            mode_d = mode_in;
            cnt_d  = '0;
        end else if (step) begin
            sr_d  = sr_step;
            cnt_d = cnt_q + CNTW'(1);
        end

        done   = step & (cnt_q == CNTW'(W - 1));
        res_lo = sr_step[W-1:0];
        res_hi = sr_step[2*W-1:W];
    end

    always_ff @(posedge execlk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            opb_q  <= '0;
            mode_q <= MD_MUL;
            cnt_q  <= '0;
        end else begin
            sr_q   <= sr_d;
            opb_q  <= opb_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/exec_alu_seq.sv
// Execute unit ahead of the accumulator: single-cycle logic/add/shift ops,
// iterative MUL/DIV, issue handshake and registered result/flag outputs.
//
// state   | meaning
// ST_IDLE | waiting for an issue; single-cycle ops complete here
// ST_MUL  | multiply iterating, one partial product per clock
// ST_DIV  | restoring divide iterating, one quotient bit per clock
module exec_alu_seq
    import exec_alu_seq_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic         execlk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   opcode,
    input  logic [W-1:0] acc_in,
    input  logic [W-1:0] operand,
    output logic         ready,
    output logic         busy,
    output logic [W-1:0] acc_res,
    output logic         ldacc,
    output logic [W-1:0] rem_out,
    output logic         zf,
    output logic         cf,
    output logic         dz,
    output logic         ill
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] acc_res_q, acc_res_d;
    logic [W-1:0] rem_q, rem_d;
    logic         ldacc_q, ldacc_d;
    logic         zf_q, zf_d;
    logic         cf_q, cf_d;
    logic         dz_q, dz_d;
    logic         ill_q, ill_d;

    logic         accept;
    logic         md_load;
    md_mode_e     md_mode;
    logic         md_done;
    logic [W-1:0] md_lo, md_hi;

    logic [4:0]   sh_amt;
    logic [W:0]   add_sum, sub_diff, shl_ext, shr_ext;
    logic [W-1:0] sc_res;
    logic         sc_cf;

    assign busy   = (state_q != ST_IDLE);
    // Holding off during the load cycle keeps acc_in from being sampled stale.
    assign ready  = ~busy & ~ldacc_q;
    assign accept = start & ready;

    exec_alu_seq_muldiv_iter #(
        .W    (W),
        .CNTW (CNTW)
    ) u_muldiv (
        .execlk  (execlk),
        .rst_n   (rst_n),
        .load    (md_load),
        .mode_in (md_mode),
        .step    (busy),
        .op_a    (acc_in),
        .op_b    (operand),
        .done    (md_done),
        .res_lo  (md_lo),
        .res_hi  (md_hi)
    );

    always_comb begin
        sh_amt   = operand[4:0];
        add_sum  = {1'b0, acc_in} + {1'b0, operand};
        sub_diff = {1'b0, acc_in} - {1'b0, operand};
        // One guard bit on each shift captures the last bit shifted out.
        shl_ext  = {1'b0, acc_in} << sh_amt;
        shr_ext  = {acc_in, 1'b0} >> sh_amt;

        sc_res = '0;
        sc_cf  = 1'b0;
        case (opcode)
            OP_ADD:  begin sc_res = add_sum[W-1:0];  sc_cf = add_sum[W];  end
            OP_SUB:  begin sc_res = sub_diff[W-1:0]; sc_cf = sub_diff[W]; end
            OP_AND:  sc_res = acc_in & operand;
            OP_OR:   sc_res = acc_in | operand;
            OP_XOR:  sc_res = acc_in ^ operand;
            OP_NOT:  sc_res = ~acc_in;
            OP_SHL:  begin sc_res = shl_ext[W-1:0]; sc_cf = shl_ext[W]; end
            OP_SHR:  begin sc_res = shr_ext[W:1];   sc_cf = shr_ext[0]; end
            OP_PASS: sc_res = operand;
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_res_d = acc_res_q;
        rem_d     = rem_q;
        ldacc_d   = 1'b0;
        zf_d      = zf_q;
        cf_d      = cf_q;
        dz_d      = dz_q;
        ill_d     = 1'b0;
        md_load   = 1'b0;
        md_mode   = MD_MUL;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!op_is_legal(opcode)) begin
                        ill_d = 1'b1;
                    end else if (opcode == OP_MUL) begin
                        state_d = ST_MUL;
                        md_load = 1'b1;
                        md_mode = MD_MUL;
                    end else if (opcode == OP_DIV && operand != '0) begin
                        state_d = ST_DIV;
                        md_load = 1'b1;
                        md_mode = MD_DIV;
                    end else if (opcode == OP_DIV) begin
                        acc_res_d = '1;
                        rem_d     = acc_in;
                        zf_d      = 1'b0;
                        cf_d      = 1'b0;
                        dz_d      = 1'b1;
                        ldacc_d   = 1'b1;
                    end else begin
                        acc_res_d = sc_res;
                        rem_d     = '0;
                        zf_d      = (sc_res == '0);
                        cf_d      = sc_cf;
                        dz_d      = 1'b0;
                        ldacc_d   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (md_done) begin
                    state_d   = ST_IDLE;
                    acc_res_d = md_lo;
                    rem_d     = '0;
                    zf_d      = (md_lo == '0);
                    cf_d      = |md_hi;
                    dz_d      = 1'b0;
                    ldacc_d   = 1'b1;
                end
            end
            ST_DIV: begin
                if (md_done) begin
                    state_d   = ST_IDLE;
                    acc_res_d = md_lo;
                    rem_d     = md_hi;
                    zf_d      = (md_lo == '0);
                    cf_d      = 1'b0;
                    dz_d      = 1'b0;
                    ldacc_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge execlk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_res_q <= '0;
            rem_q     <= '0;
            ldacc_q   <= 1'b0;
            zf_q      <= 1'b0;
            cf_q      <= 1'b0;
            dz_q      <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_res_q <= acc_res_d;
            rem_q     <= rem_d;
            ldacc_q   <= ldacc_d;
            zf_q      <= zf_d;
            cf_q      <= cf_d;
            dz_q      <= dz_d;
            ill_q     <= ill_d;
        end
    end

    assign acc_res = acc_res_q;
    assign rem_out = rem_q;
    assign ldacc   = ldacc_q;
    assign zf      = zf_q;
    assign cf      = cf_q;
    assign dz      = dz_q;
    assign ill     = ill_q;

endmodule
